// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Provides the TX state encoding and the default baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // 100 MHz PCLK / 115200 baud
  localparam int unsigned BAUD_DIV_DEF = 868;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1, tick on the last count.
// Ports: PCLK, PRESETn (async low), clr (sync restart), tick (out).
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_cnt <= '0;
    end else if (clr || baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  assign tick = (baud_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and sends each byte as an 8N1/8N2 frame.
// Ports: PCLK, PRESETn, en, fifo_empty, fifo_rdata, fifo_rd_en, tx, tx_busy, tx_done.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rdata,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [BW-1:0]        bit_cnt;
  logic                 tick;
  logic                 last_stop;
  logic                 pop;

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .clr    (pop),
    .tick   (tick)
  );

  assign shift_nxt = shift_reg >> 1;
  assign last_stop = (state == STOP) && tick
                  && (bit_cnt == LAST_STOP);

  // Reset gates the pop so a non-empty FIFO is never drained in reset.
  assign pop = PRESETn && en && !fifo_empty
            && ((state == IDLE) || last_stop);
  assign fifo_rd_en = pop;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (pop) begin
        // Also covers back-to-back: finishing frame still reports done.
        shift_reg <= fifo_rdata;
        bit_cnt   <= '0;
        state     <= START;
        tx        <= 1'b0;
        tx_busy   <= 1'b1;
        tx_done   <= last_stop;
      end else begin
        unique case (state)
          IDLE: begin
          end
          START: begin
            if (tick) begin
              state <= DATA;
              tx    <= shift_reg[0];
            end
          end
          DATA: begin
            if (tick) begin
              shift_reg <= shift_nxt;
              if (bit_cnt == LAST_DATA) begin
                state   <= STOP;
                bit_cnt <= '0;
                tx      <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                tx      <= shift_nxt[0];
              end
            end
          end
          STOP: begin
            if (tick) begin
              if (bit_cnt == LAST_STOP) begin
                state   <= IDLE;
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                tx      <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule
